hdmi_packet_serializer: RTL and testbench



---
 rtl/hdmi_pkg.sv | 21 ++
 rtl/bch_ecc_step.sv | 30 +++
 rtl/hdmi_packet_serializer.sv | 143 ++++++++++++++
 tb/tb_hdmi_packet_serializer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// ---------------------------------------------------------------------------
// hdmi_pkg
// Shared constants and types for the HDMI data-island packet path.
//   PACKET_LEN       : pixel clocks per data-island packet
//   BCH_POLY         : reflected feedback constant for x^8+x^7+x^6+1
//   HDR_DATA_SLOTS   : slots carrying header bits (the rest carry header ECC)
//   SUB_DATA_SLOTS   : slots carrying subpacket bits (the rest carry ECC)
//   packet_header_t  : HB2:HB1:HB0, HB0 in [7:0]
//   subpacket_t      : 7 bytes, byte k in [8k+7:8k]
// ---------------------------------------------------------------------------
package hdmi_pkg;

  localparam int         PACKET_LEN     = 32;
  localparam logic [7:0] BCH_POLY       = 8'b1000_0011;
  localparam int         HDR_DATA_SLOTS = 24;
  localparam int         SUB_DATA_SLOTS = 28;

  typedef logic [23:0] packet_header_t;
  typedef logic [55:0] subpacket_t;

endpackage

// File: rtl/bch_ecc_step.sv
// ---------------------------------------------------------------------------
// bch_ecc_step
// Combinational BCH parity update over BITS_PER_CYCLE serial bits, lowest
// index bit shifted in first.
//   ecc_in  : parity register value before this cycle
//   bits    : data bits entering the generator this cycle
//   ecc_out : parity after all bits have been absorbed
// ---------------------------------------------------------------------------
module bch_ecc_step
  import hdmi_pkg::*;
#(
  parameter int         BITS_PER_CYCLE = 1,
  parameter logic [7:0] POLY           = BCH_POLY
) (
  input  logic [7:0]                ecc_in,
  input  logic [BITS_PER_CYCLE-1:0] bits,
  output logic [7:0]                ecc_out
);

  logic [7:0] ecc_tmp;

  always_comb begin
    ecc_tmp = ecc_in;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      ecc_tmp = (ecc_tmp >> 1) ^ ((ecc_tmp[0] ^ bits[k]) ? POLY : 8'h00);
    end
    ecc_out = ecc_tmp;
  end

endmodule

// File: rtl/hdmi_packet_serializer.sv
// ---------------------------------------------------------------------------
// hdmi_packet_serializer
// Serialises one HDMI data-island packet (header + four subpackets + BCH
// parity) into 9 bits per pixel clock over 32 clocks.
//   clk_pixel          : pixel clock
//   reset_n            : asynchronous active-low reset
//   data_island_period : high while the packet payload period is active
//   header             : HB2:HB1:HB0
//   sub                : four 56-bit subpackets
//   packet_data        : bit 0 header lane, bits 2i+1/2i+2 subpacket lane i
//   packet_counter     : slot index currently on packet_data (0 when idle)
//   packet_load        : high in the cycle a packet snapshot is taken
//                        (slot 31 output, or slot 0 of a fresh island)
//   packet_done        : high together with slot 31
// ---------------------------------------------------------------------------
module hdmi_packet_serializer #(
  parameter int         PACKET_LEN = hdmi_pkg::PACKET_LEN,
  parameter logic [7:0] BCH_POLY   = hdmi_pkg::BCH_POLY
) (
  input  logic             clk_pixel,
  input  logic             reset_n,
  input  logic             data_island_period,
  input  logic [23:0]      header,
  input  logic [3:0][55:0] sub,
  output logic [8:0]       packet_data,
  output logic [4:0]       packet_counter,
  output logic             packet_load,
  output logic             packet_done
);

  localparam logic [4:0] LAST_SLOT = 5'(PACKET_LEN - 1);
  localparam logic [4:0] HDR_SLOTS = 5'(hdmi_pkg::HDR_DATA_SLOTS);
  localparam logic [4:0] SUB_SLOTS = 5'(hdmi_pkg::SUB_DATA_SLOTS);

  logic [4:0]                 cnt_reg;
  logic                       active_reg;
  hdmi_pkg::packet_header_t   hdr_shadow_reg;
  logic [3:0][55:0]           sub_shadow_reg;
  logic [7:0]                 hecc_reg;
  logic [3:0][7:0]            secc_reg;

  logic                       start;
  logic                       hdr_data_slot;
  logic                       sub_data_slot;
  hdmi_pkg::packet_header_t   hdr_src;
  logic [3:0][55:0]           sub_src;
  logic [7:0]                 hecc_cur;
  logic [7:0]                 hecc_next;
  logic [3:0][7:0]            secc_cur;
  logic [3:0][7:0]            secc_next;
  logic                       hdr_bit;
  logic [3:0][1:0]            sub_pair;
  logic [5:0]                 sub_idx;
  logic [2:0]                 secc_idx;
  logic [8:0]                 data_next;

  // Slot 0 is served straight from the live inputs while the shadows load,
  // and the parity chain starts from zero instead of last packet's value.
  assign start         = data_island_period && (cnt_reg == 5'd0);
  assign hdr_data_slot = (cnt_reg < HDR_SLOTS);
  assign sub_data_slot = (cnt_reg < SUB_SLOTS);
  assign hdr_src       = start ? header : hdr_shadow_reg;
  assign sub_src       = start ? sub : sub_shadow_reg;
  assign hecc_cur      = start ? 8'h00 : hecc_reg;
  assign secc_cur      = start ? '0 : secc_reg;

  // Parity slots 24..31 map to hecc bit cnt-24, which is simply cnt[2:0].
  assign hdr_bit  = hdr_data_slot ? hdr_src[cnt_reg] : hecc_cur[cnt_reg[2:0]];
  assign sub_idx  = {cnt_reg, 1'b0};
  assign secc_idx = {cnt_reg[1:0], 1'b0};

  bch_ecc_step #(
    .BITS_PER_CYCLE(1),
    .POLY          (BCH_POLY)
  ) u_hdr_ecc (
    .ecc_in (hecc_cur),
    .bits   (hdr_bit),
    .ecc_out(hecc_next)
  );

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sub_lane
      assign sub_pair[gi] = sub_data_slot ? sub_src[gi][sub_idx +: 2]
                                          : secc_cur[gi][secc_idx +: 2];

      bch_ecc_step #(
        .BITS_PER_CYCLE(2),
        .POLY          (BCH_POLY)
      ) u_sub_ecc (
        .ecc_in (secc_cur[gi]),
        .bits   (sub_pair[gi]),
        .ecc_out(secc_next[gi])
      );

      assign data_next[2*gi+2 -: 2] = sub_pair[gi];
    end
  endgenerate

  assign data_next[0] = hdr_bit;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg        <= '0;
      active_reg     <= 1'b0;
      hdr_shadow_reg <= '0;
      sub_shadow_reg <= '0;
      hecc_reg       <= '0;
      secc_reg       <= '0;
      packet_data    <= '0;
      packet_counter <= '0;
      packet_load    <= 1'b0;
      packet_done    <= 1'b0;
    end else begin
      active_reg <= data_island_period;
      if (data_island_period) begin
        cnt_reg        <= cnt_reg + 5'd1;
        packet_data    <= data_next;
        packet_counter <= cnt_reg;
        packet_done    <= (cnt_reg == LAST_SLOT);
        // Either the wrap into the next packet or the first island cycle.
        packet_load    <= (cnt_reg == LAST_SLOT) || !active_reg;
        if (start) begin
          hdr_shadow_reg <= header;
          sub_shadow_reg <= sub;
        end
        if (hdr_data_slot) begin
          hecc_reg <= hecc_next;
        end
        if (sub_data_slot) begin
          secc_reg <= secc_next;
        end
      end else begin
        // Leaving the island abandons any partial packet without a done pulse.
        cnt_reg        <= '0;
        packet_data    <= '0;
        packet_counter <= '0;
        packet_done    <= 1'b0;
        packet_load    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_packet_serializer.sv
module tb_hdmi_packet_serializer;

  logic             clk_pixel = 1'b0;
  logic             reset_n;
  logic             data_island_period;
  logic [23:0]      header;
  logic [3:0][55:0] sub;
  logic [8:0]       packet_data;
  logic [4:0]       packet_counter;
  logic             packet_load;
  logic             packet_done;

  always #5 clk_pixel = ~clk_pixel;

  hdmi_packet_serializer dut (
    .clk_pixel         (clk_pixel),
    .reset_n           (reset_n),
    .data_island_period(data_island_period),
    .header            (header),
    .sub               (sub),
    .packet_data       (packet_data),
    .packet_counter    (packet_counter),
    .packet_load       (packet_load),
    .packet_done       (packet_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] bch_of(input logic [55:0] bits, input int n);
    logic [7:0] e;
    e = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (e[0] ^ bits[i]) e = (e >> 1) ^ 8'h83;
      else e = e >> 1;
    end
    return e;
  endfunction

  logic [8:0] exp_slots [32];

  function automatic void build_packet(input logic [23:0] h, input logic [3:0][55:0] s);
    logic [7:0] hecc;
    logic [7:0] secc [4];
    logic [8:0] w;
    hecc = bch_of({32'h0, h}, 24);
    for (int i = 0; i < 4; i++) secc[i] = bch_of(s[i], 56);
    for (int c = 0; c < 32; c++) begin
      w = '0;
      w[0] = (c < 24) ? h[c] : hecc[c-24];
      for (int i = 0; i < 4; i++) begin
        if (c < 28) begin
          w[2*i+1] = s[i][2*c];
          w[2*i+2] = s[i][2*c+1];
        end else begin
          w[2*i+1] = secc[i][2*(c-28)];
          w[2*i+2] = secc[i][2*(c-28)+1];
        end
      end
      exp_slots[c] = w;
    end
  endfunction

  // ---------------- cycle checker ----------------
  int         m_cnt  = 0;
  bit         m_prev = 1'b0;
  logic [8:0] obs_slots [32];
  logic       obs_load  [32];
  int         done_cnt = 0;

  initial begin
    logic [8:0] e_data;
    logic [4:0] e_cnt;
    logic       e_done, e_load, in_pkt;
    int         slot;
    forever begin
      @(posedge clk_pixel);
      in_pkt = 1'b0;
      slot   = 0;
      if (!reset_n) begin
        e_data = '0; e_cnt = '0; e_done = 1'b0; e_load = 1'b0;
        m_cnt = 0; m_prev = 1'b0;
      end else if (data_island_period) begin
        if (m_cnt == 0) build_packet(header, sub);
        e_data = exp_slots[m_cnt];
        e_cnt  = 5'(m_cnt);
        e_done = (m_cnt == 31);
        e_load = (m_cnt == 31) || !m_prev;
        slot   = m_cnt;
        in_pkt = 1'b1;
        m_cnt  = (m_cnt + 1) % 32;
        m_prev = 1'b1;
      end else begin
        e_data = '0; e_cnt = '0; e_done = 1'b0; e_load = 1'b0;
        m_cnt = 0; m_prev = 1'b0;
      end
      #1;
      $display("cyc t=%0t slot=%0d data=%03h cnt=%0d load=%0b done=%0b",
               $time, e_cnt, packet_data, packet_counter, packet_load, packet_done);
      check("packet_data", 32'(packet_data), 32'(e_data));
      check("packet_counter", 32'(packet_counter), 32'(e_cnt));
      check("packet_done", 32'(packet_done), 32'(e_done));
      check("packet_load", 32'(packet_load), 32'(e_load));
      if (in_pkt) begin
        obs_slots[slot] = packet_data;
        obs_load[slot]  = packet_load;
      end
      if (packet_done) done_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic randomize_inputs();
    header = 24'($urandom);
    for (int i = 0; i < 4; i++) sub[i] = {24'($urandom), $urandom};
  endtask

  task automatic run_island(input int n, input bit rnd);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_pixel);
      data_island_period = 1'b1;
      if (rnd) randomize_inputs();
    end
    @(negedge clk_pixel);
    data_island_period = 1'b0;
  endtask

  initial begin
    logic [8:0] acc;
    logic [7:0] byte_obs;
    logic [7:0] ecc_obs;
    logic [7:0] ecc_ref;
    int         loads_mid;

    reset_n = 1'b0;
    data_island_period = 1'b0;
    header = '0;
    sub = '0;
    #1;
    check("reset_data", 32'(packet_data), 32'h0);
    check("reset_counter", 32'(packet_counter), 32'h0);
    repeat (3) @(negedge clk_pixel);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_pixel);

    // All-zero packet
    done_cnt = 0;
    run_island(32, 1'b0);
    acc = '0;
    loads_mid = 0;
    for (int c = 0; c < 32; c++) acc |= obs_slots[c];
    for (int c = 1; c < 31; c++) if (obs_load[c]) loads_mid++;
    check("zero_all_slots", 32'(acc), 32'h0);
    check("zero_done_count", 32'(done_cnt), 32'd1);
    check("zero_load_slot0", 32'(obs_load[0]), 32'd1);
    check("zero_load_mid", 32'(loads_mid), 32'd0);

    // ACR header byte: header parity must be 8'h4A
    header = 24'h000001;
    sub = '0;
    run_island(32, 1'b0);
    byte_obs = '0;
    acc = '0;
    for (int c = 24; c < 32; c++) byte_obs[c-24] = obs_slots[c][0];
    for (int c = 1; c < 24; c++) acc[0] = acc[0] | obs_slots[c][0];
    check("acr_slot0_bit0", 32'(obs_slots[0][0]), 32'd1);
    check("acr_hdr_body", 32'(acc), 32'd0);
    check("acr_hdr_ecc", 32'(byte_obs), 32'h4A);

    // Single bit in subpacket 0
    header = '0;
    sub = '0;
    sub[0] = 56'h1;
    run_island(32, 1'b0);
    ecc_obs = '0;
    acc = '0;
    for (int c = 28; c < 32; c++) begin
      ecc_obs[2*(c-28)]   = obs_slots[c][1];
      ecc_obs[2*(c-28)+1] = obs_slots[c][2];
    end
    for (int c = 0; c < 32; c++) acc = acc | {3'b0, obs_slots[c][8:3]};
    ecc_ref = bch_of(56'h1, 56);
    check("sub0_slot0_bit1", 32'(obs_slots[0][1]), 32'd1);
    check("sub0_ecc", 32'(ecc_obs), 32'(ecc_ref));
    check("sub_lanes_quiet", 32'(acc), 32'h0);

    // Back-to-back random packets, inputs churn every cycle
    done_cnt = 0;
    run_island(128, 1'b1);
    check("b2b_done_count", 32'(done_cnt), 32'd4);

    // Abort at cnt==15, then a fresh island
    done_cnt = 0;
    run_island(16, 1'b1);
    repeat (2) @(negedge clk_pixel);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_island(32, 1'b1);
    check("after_abort_done", 32'(done_cnt), 32'd1);

    // Asynchronous reset at slot 20
    for (int k = 0; k < 21; k++) begin
      @(negedge clk_pixel);
      data_island_period = 1'b1;
      randomize_inputs();
    end
    @(negedge clk_pixel);
    check("pre_reset_counter", 32'(packet_counter), 32'd20);
    reset_n = 1'b0;
    data_island_period = 1'b0;
    #1;
    check("async_rst_data", 32'(packet_data), 32'h0);
    check("async_rst_counter", 32'(packet_counter), 32'h0);
    check("async_rst_done", 32'(packet_done), 32'h0);
    check("async_rst_load", 32'(packet_load), 32'h0);
    repeat (2) @(negedge clk_pixel);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_pixel);
    run_island(64, 1'b1);
    repeat (2) @(negedge clk_pixel);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
